hcm_access_arbiter: RTL and testbench
=====================================

Name: hcm_access_arbiter

Overview:
Shares the single HCM port (writeRow/readRow/SSIDIsNew interface) between NREQ hit/readout requesters using round-robin arbitration, one request issued per cycle. Tracks which HCM rows were written this event in a seen-bitmap and derives SSIDIsNew from it. On event end it stops granting, drains the HCM pipeline, clears the bitmap and signals event completion.

Parameters:
NREQ, 4, number of requesters
ROW_BITS, 8, HCM row index width; bitmap holds 2**ROW_BITS bits
DRAIN_CYCLES, 8, idle cycles required after last issue before clear; covers BRAM read delay plus HCM queue depth

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
req_valid  in  NREQ  per-requester request valid
req_write  in  NREQ  1 = hit write (increment), 0 = row read
req_row  in  NREQ*ROW_BITS  row index; requester k at bits [k*ROW_BITS +: ROW_BITS]
req_ready  out  NREQ  one-hot grant; handshake when req_valid[k] & req_ready[k]
event_end  in  1  single-cycle pulse: no more requests this event
hcm_busy  in  1  HCM busy/queue-nonempty indication
hcm_write_row  out  1  drives HCM writeRow
hcm_read_row  out  1  drives HCM readRow
hcm_row  out  ROW_BITS  row for either operation
hcm_ssid_is_new  out  1  drives HCM SSIDIsNew; valid with hcm_write_row
issued_id  out  log2(NREQ) (min 1)  requester index of current issue
new_row_count  out  ROW_BITS+1  number of distinct rows written this event
event_done  out  1  single-cycle pulse after clear completes

Behaviour:
- Reset: state RUN, rr pointer 0, bitmap all 0, drain counter 0, all outputs 0, event_end latch 0.
- States: RUN, DRAIN, CLEAR.
- RUN: req_ready combinational, one-hot, at most one bit set; grant goes to the first valid requester at or after rr pointer (wrap mod NREQ). After a handshake, rr pointer = granted index + 1 (wrap). No handshake leaves the pointer unchanged.
- Issue latency: 1 cycle. In the cycle after a handshake:
  - hcm_write_row = req_write and hcm_read_row = !req_write (never both high).
  - hcm_row and issued_id are registered from the granted request.
  - Both strobes are 0 in cycles without a handshake.
- Write with bitmap[row]==0: hcm_ssid_is_new = 1, bitmap[row] set, new_row_count incremented. Write with bitmap[row]==1: hcm_ssid_is_new = 0.
- A later write to the same row sees the updated bit. Since there is at most one issue per cycle, back-to-back writes to one row yield new=1, then new=0.
- Reads never modify the bitmap; hcm_ssid_is_new = 0 on reads.
- new_row_count saturates at 2**ROW_BITS; it cannot exceed that by construction.
- event_end in RUN:
  - The handshake in the same cycle (if any) still completes.
  - From the next cycle req_ready = 0; go to DRAIN and clear the drain counter.
- DRAIN:
  - Counter increments each cycle that hcm_busy == 0, and resets to 0 whenever hcm_busy == 1.
  - When counter == DRAIN_CYCLES-1 with hcm_busy == 0, go to CLEAR.
  - event_end pulses in DRAIN or CLEAR are ignored (not queued).
- CLEAR (1 cycle): bitmap zeroed, new_row_count zeroed, event_done = 1, rr pointer unchanged; next state RUN.
- Requests held valid during DRAIN/CLEAR are granted normally once back in RUN; requesters must keep valid/row stable until handshake.
- Reset mid-DRAIN or mid-CLEAR: immediate return to reset state; event_done is not pulsed.

Optional Feature:
HCM_WRITE_PRIORITY_EN
- Defined: two-level arbitration. If any valid requester has req_write=1, the round-robin search considers only write requesters; reads are granted only in cycles with no valid write. The rr pointer update rule is unchanged.
- Undefined: plain round-robin ignoring request type.

Test Plan:
- Reset, then req 0 writes row 5 twice (consecutive handshakes) -> cycle+1: hcm_write_row=1, hcm_row=5, hcm_ssid_is_new=1; next: ssid_is_new=0; new_row_count=1.
- All 4 requesters valid constantly writing rows 1,2,3,4 -> grants in order 0,1,2,3,0,...; issued_id follows; each requester gets exactly 1 of every 4 issues.
- Req 2 reads row 9 (never written) -> hcm_read_row=1, hcm_row=9, ssid_is_new=0, bitmap and new_row_count unchanged.
- Write rows 3,7; pulse event_end; hold hcm_busy=1 for 5 cycles -> req_ready=0 throughout; event_done pulses exactly DRAIN_CYCLES(8) cycles after hcm_busy falls. Afterwards, a write to row 3 has ssid_is_new=1 and new_row_count reads 1.
- event_end pulsed again during DRAIN; reset asserted in DRAIN of a second event -> second pulse has no effect; after reset event_done stays 0, bitmap is clear, state is RUN.
- With HCM_WRITE_PRIORITY_EN: req 0 read and req 1 write both valid, pointer at 0 -> req 1 granted first, req 0 next cycle. Without the macro -> req 0 granted first.

Source files
------------

// File: rtl/hcm_access_arbiter.sv
// Round-robin arbiter sharing one HCM port among NREQ requesters, with a per-event seen-row bitmap.
// Optional macro HCM_WRITE_PRIORITY_EN: grant writes ahead of reads.
module hcm_access_arbiter #(
    parameter int NREQ         = 4,
    parameter int ROW_BITS     = 8,
    parameter int DRAIN_CYCLES = 8,
    localparam int ID_BITS     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ-1:0]          req_write,
    input  logic [NREQ*ROW_BITS-1:0] req_row,
    output logic [NREQ-1:0]          req_ready,
    input  logic                     event_end,
    input  logic                     hcm_busy,
    output logic                     hcm_write_row,
    output logic                     hcm_read_row,
    output logic [ROW_BITS-1:0]      hcm_row,
    output logic                     hcm_ssid_is_new,
    output logic [ID_BITS-1:0]       issued_id,
    output logic [ROW_BITS:0]        new_row_count,
    output logic                     event_done
);

    localparam int DEPTH    = 1 << ROW_BITS;
    localparam int CNT_BITS = $clog2(DRAIN_CYCLES + 1);
    localparam int CNT_W    = ROW_BITS + 1;

    typedef enum logic [1:0] {RUN, DRAIN, CLEAR} state_t;

    state_t               state_reg;
    logic [ID_BITS-1:0]   rr_ptr_reg;
    logic [DEPTH-1:0]     bitmap_reg;
    logic [CNT_BITS-1:0]  drain_cnt_reg;
    logic [CNT_W-1:0]     new_count_reg;
    logic                 write_row_reg;
    logic                 read_row_reg;
    logic                 ssid_new_reg;
    logic [ROW_BITS-1:0]  row_reg;
    logic [ID_BITS-1:0]   id_reg;
    logic                 event_done_reg;

    logic [ROW_BITS-1:0]  row_arr [NREQ];
    logic [NREQ-1:0]      cand;
    logic                 grant_found;
    logic [ID_BITS-1:0]   grant_idx;
    logic [ID_BITS-1:0]   rr_ptr_next;
    logic [ROW_BITS-1:0]  grant_row;
    logic                 grant_write;
    logic                 handshake;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_row_unpack
        assign row_arr[gi] = req_row[gi*ROW_BITS +: ROW_BITS];
    end

    // Candidate set; with write priority, reads compete only when no write is pending.
    always_comb begin
        cand = req_valid;
`ifdef HCM_WRITE_PRIORITY_EN
        if ((req_valid & req_write) != '0)
            cand = req_valid & req_write;
`endif
    end

    always_comb begin
        int idx;
        idx         = 0;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = int'(rr_ptr_reg) + i;
            if (idx >= NREQ)
                idx = idx - NREQ;
            if (!grant_found && cand[idx]) begin
                grant_found = 1'b1;
                grant_idx   = ID_BITS'(idx);
            end
        end
    end

    assign handshake   = (state_reg == RUN) && grant_found;
    assign req_ready   = handshake ? (NREQ'(1) << grant_idx) : '0;
    assign grant_row   = row_arr[grant_idx];
    assign grant_write = req_write[grant_idx];
    assign rr_ptr_next = (grant_idx == ID_BITS'(NREQ - 1)) ? '0 : grant_idx + ID_BITS'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= RUN;
            rr_ptr_reg     <= '0;
            bitmap_reg     <= '0;
            drain_cnt_reg  <= '0;
            new_count_reg  <= '0;
            write_row_reg  <= 1'b0;
            read_row_reg   <= 1'b0;
            ssid_new_reg   <= 1'b0;
            row_reg        <= '0;
            id_reg         <= '0;
            event_done_reg <= 1'b0;
        end else begin
            write_row_reg  <= 1'b0;
            read_row_reg   <= 1'b0;
            ssid_new_reg   <= 1'b0;
            event_done_reg <= 1'b0;
            case (state_reg)
                RUN: begin
                    if (handshake) begin
                        rr_ptr_reg    <= rr_ptr_next;
                        row_reg       <= grant_row;
                        id_reg        <= grant_idx;
                        write_row_reg <= grant_write;
                        read_row_reg  <= !grant_write;
                        // First write to a row this event marks it new.
                        if (grant_write && !bitmap_reg[grant_row]) begin
                            ssid_new_reg          <= 1'b1;
                            bitmap_reg[grant_row] <= 1'b1;
                            if (new_count_reg != CNT_W'(DEPTH))
                                new_count_reg <= new_count_reg + CNT_W'(1);
                        end
                    end
                    if (event_end) begin
                        state_reg     <= DRAIN;
                        drain_cnt_reg <= '0;
                    end
                end
                DRAIN: begin
                    if (hcm_busy) begin
                        drain_cnt_reg <= '0;
                    end else if (drain_cnt_reg == CNT_BITS'(DRAIN_CYCLES - 1)) begin
                        state_reg      <= CLEAR;
                        drain_cnt_reg  <= '0;
                        bitmap_reg     <= '0;
                        new_count_reg  <= '0;
                        event_done_reg <= 1'b1;
                    end else begin
                        drain_cnt_reg <= drain_cnt_reg + CNT_BITS'(1);
                    end
                end
                CLEAR: begin
                    state_reg <= RUN;
                end
                default: begin
                    state_reg <= RUN;
                end
            endcase
        end
    end

    assign hcm_write_row   = write_row_reg;
    assign hcm_read_row    = read_row_reg;
    assign hcm_row         = row_reg;
    assign hcm_ssid_is_new = ssid_new_reg;
    assign issued_id       = id_reg;
    assign new_row_count   = new_count_reg;
    assign event_done      = event_done_reg;

endmodule

// File: tb/tb_hcm_access_arbiter.sv
// Directed bench for hcm_access_arbiter: a small reference model feeds a scoreboard of expected issues.
module tb_hcm_access_arbiter;

    localparam int NREQ     = 4;
    localparam int ROW_BITS = 8;
    localparam int DRAIN    = 8;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [NREQ-1:0]          req_valid;
    logic [NREQ-1:0]          req_write;
    logic [NREQ*ROW_BITS-1:0] req_row;
    logic [NREQ-1:0]          req_ready;
    logic                     event_end;
    logic                     hcm_busy;
    logic                     hcm_write_row;
    logic                     hcm_read_row;
    logic [ROW_BITS-1:0]      hcm_row;
    logic                     hcm_ssid_is_new;
    logic [1:0]               issued_id;
    logic [ROW_BITS:0]        new_row_count;
    logic                     event_done;

    hcm_access_arbiter #(.NREQ(NREQ), .ROW_BITS(ROW_BITS), .DRAIN_CYCLES(DRAIN)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_write(req_write), .req_row(req_row), .req_ready(req_ready),
        .event_end(event_end), .hcm_busy(hcm_busy),
        .hcm_write_row(hcm_write_row), .hcm_read_row(hcm_read_row), .hcm_row(hcm_row),
        .hcm_ssid_is_new(hcm_ssid_is_new), .issued_id(issued_id),
        .new_row_count(new_row_count), .event_done(event_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic                write;
        logic [ROW_BITS-1:0] row;
        int                  id;
        logic                is_new;
        int                  count;
    } issue_t;

    issue_t       scb[$];
    int           tests  = 0;
    int           failed = 0;
    bit [255:0]   m_bitmap;
    int           m_count;
    int           m_rr;
    bit           m_run;
    int           m_last_grant;
    int           grants[NREQ];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_grant();
        logic [NREQ-1:0] c;
        int k;
        c = req_valid;
`ifdef HCM_WRITE_PRIORITY_EN
        if ((req_valid & req_write) != '0)
            c = req_valid & req_write;
`endif
        if (!m_run)
            return -1;
        for (int i = 0; i < NREQ; i++) begin
            k = (m_rr + i) % NREQ;
            if (c[k])
                return k;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_bitmap = '0;
        m_count  = 0;
        m_rr     = 0;
        m_run    = 1'b1;
        scb.delete();
    endtask

    task automatic set_req(input int k, input bit v, input bit w, input int row);
        req_valid[k] = v;
        req_write[k] = w;
        req_row[k*ROW_BITS +: ROW_BITS] = ROW_BITS'(row);
    endtask

    // One clock cycle: check grant, push expected issue, then check the registered result.
    task automatic tick(input bit exp_done);
        int g;
        issue_t e;
        logic [NREQ-1:0] er;
        g  = model_grant();
        er = (g >= 0) ? (NREQ'(1) << g) : '0;
        #1;
        chk("req_ready", 32'(req_ready), 32'(er));
        if (g >= 0) begin
            e.write  = req_write[g];
            e.row    = req_row[g*ROW_BITS +: ROW_BITS];
            e.id     = g;
            e.is_new = e.write && !m_bitmap[e.row];
            if (e.is_new) begin
                m_bitmap[e.row] = 1'b1;
                m_count++;
            end
            e.count = m_count;
            scb.push_back(e);
            m_rr = (g + 1) % NREQ;
            grants[g]++;
        end
        m_last_grant = g;
        @(posedge clk); #1;
        if (scb.size() > 0) begin
            e = scb.pop_front();
            $display("[TB] issue id=%0d write=%0b row=%0d new=%0b count=%0d", e.id, e.write, e.row, e.is_new, e.count);
            chk("hcm_write_row", 32'(hcm_write_row), 32'(e.write));
            chk("hcm_read_row", 32'(hcm_read_row), 32'(!e.write));
            chk("hcm_row", 32'(hcm_row), 32'(e.row));
            chk("issued_id", 32'(issued_id), 32'(e.id));
            chk("ssid_is_new", 32'(hcm_ssid_is_new), 32'(e.is_new));
            chk("new_row_count", 32'(new_row_count), 32'(e.count));
        end else begin
            chk("idle_strobes", 32'({hcm_write_row, hcm_read_row}), 32'(0));
        end
        chk("event_done", 32'(event_done), 32'(exp_done));
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        chk("rst_strobes", 32'({hcm_write_row, hcm_read_row, hcm_ssid_is_new}), 32'(0));
        chk("rst_row_id", 32'({hcm_row, issued_id}), 32'(0));
        chk("rst_count", 32'(new_row_count), 32'(0));
        chk("rst_done", 32'(event_done), 32'(0));
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_write = '0;
        req_row   = '0;
        event_end = 1'b0;
        hcm_busy  = 1'b0;
        for (int i = 0; i < NREQ; i++) grants[i] = 0;
        @(posedge clk); #1;
        do_reset(3);

        // Same row written on consecutive handshakes: new, then not new.
        set_req(0, 1, 1, 5);
        tick(0);
        tick(0);
        req_valid = '0;
        tick(0);
        chk("count_after_row5", 32'(new_row_count), 32'(1));

        // All requesters writing: strict rotation, equal share.
        for (int i = 0; i < NREQ; i++) begin
            set_req(i, 1, 1, i + 1);
            grants[i] = 0;
        end
        for (int i = 0; i < 2 * NREQ; i++) tick(0);
        for (int i = 0; i < NREQ; i++) chk($sformatf("share_req%0d", i), 32'(grants[i]), 32'(2));
        req_valid = '0;
        tick(0);

        // Read of an unwritten row leaves the bitmap alone; a later write to it is still new.
        set_req(2, 1, 0, 9);
        tick(0);
        req_valid = '0;
        chk("count_after_read", 32'(new_row_count), 32'(5));
        set_req(2, 1, 1, 9);
        tick(0);
        req_valid = '0;

        // Event end with a concurrent handshake, busy HCM, then drain and clear.
        set_req(0, 1, 1, 3);
        set_req(1, 1, 1, 7);
        tick(0);
        tick(0);
        req_valid = '0;
        set_req(3, 1, 1, 200);
        event_end = 1'b1;
        tick(0);
        event_end = 1'b0;
        m_run     = 1'b0;
        req_valid = '0;
        set_req(0, 1, 1, 3);
        hcm_busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            event_end = (i == 2);
            tick(0);
        end
        event_end = 1'b0;
        hcm_busy  = 1'b0;
        for (int k = 1; k <= DRAIN; k++) tick(k == DRAIN);
        chk("clear_count", 32'(new_row_count), 32'(0));
        m_bitmap = '0;
        m_count  = 0;
        tick(0);
        m_run = 1'b1;
        tick(0);
        req_valid = '0;
        chk("post_clear_count", 32'(new_row_count), 32'(1));

        // Second event: extra event_end in drain, then reset mid-drain.
        event_end = 1'b1;
        tick(0);
        m_run = 1'b0;
        for (int i = 0; i < 3; i++) begin
            event_end = (i == 1);
            tick(0);
        end
        event_end = 1'b0;
        do_reset(1);
        for (int i = 0; i < 12; i++) tick(0);
        set_req(0, 1, 1, 3);
        tick(0);
        req_valid = '0;
        chk("post_reset_count", 32'(new_row_count), 32'(1));

        // Read vs write contention with pointer at 0.
        do_reset(1);
        set_req(0, 1, 0, 10);
        set_req(1, 1, 1, 11);
        tick(0);
`ifdef HCM_WRITE_PRIORITY_EN
        chk("prio_first", 32'(m_last_grant), 32'(1));
`else
        chk("prio_first", 32'(m_last_grant), 32'(0));
`endif
        if (m_last_grant >= 0) req_valid[m_last_grant] = 1'b0;
        tick(0);
`ifdef HCM_WRITE_PRIORITY_EN
        chk("prio_second", 32'(m_last_grant), 32'(0));
`else
        chk("prio_second", 32'(m_last_grant), 32'(1));
`endif
        req_valid = '0;
        tick(0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
